ps2_note_decoder: RTL



---
 rtl/ps2_note_pkg.sv | 59 +++++
 rtl/note_stack.sv | 85 ++++++++
 rtl/ps2_note_decoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ps2_note_pkg.sv
// Shared scan-code constants, parser states and key lookup for the PS/2 note decoder.
package ps2_note_pkg;

    localparam logic [7:0] ScBreak   = 8'hF0;
    localparam logic [7:0] ScExt     = 8'hE0;
    localparam logic [7:0] ScOctDown = 8'h1A;
    localparam logic [7:0] ScOctUp   = 8'h22;
    localparam logic [7:0] ScSpace   = 8'h29;

    localparam logic [7:0] ScN0  = 8'h1C;
    localparam logic [7:0] ScN1  = 8'h1D;
    localparam logic [7:0] ScN2  = 8'h1B;
    localparam logic [7:0] ScN3  = 8'h24;
    localparam logic [7:0] ScN4  = 8'h23;
    localparam logic [7:0] ScN5  = 8'h2B;
    localparam logic [7:0] ScN6  = 8'h2C;
    localparam logic [7:0] ScN7  = 8'h34;
    localparam logic [7:0] ScN8  = 8'h35;
    localparam logic [7:0] ScN9  = 8'h33;
    localparam logic [7:0] ScN10 = 8'h3C;
    localparam logic [7:0] ScN11 = 8'h3B;
    localparam logic [7:0] ScN12 = 8'h42;

    typedef enum logic [1:0] {
        StIdle,
        StBreak,
        StExt,
        StExtBreak
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] note;
    } key_t;

    function automatic key_t key_lookup(input logic [7:0] code);
        key_t k;
        k.hit  = 1'b1;
        k.note = 4'd0;
        case (code)
            ScN0:    k.note = 4'd0;
            ScN1:    k.note = 4'd1;
            ScN2:    k.note = 4'd2;
            ScN3:    k.note = 4'd3;
            ScN4:    k.note = 4'd4;
            ScN5:    k.note = 4'd5;
            ScN6:    k.note = 4'd6;
            ScN7:    k.note = 4'd7;
            ScN8:    k.note = 4'd8;
            ScN9:    k.note = 4'd9;
            ScN10:   k.note = 4'd10;
            ScN11:   k.note = 4'd11;
            ScN12:   k.note = 4'd12;
            default: k.hit  = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/note_stack.sv
// Last-note-priority held-key stack: entry 0 is the oldest, the top is entry count-1.
// Exposes next-state top/empty so the caller can register outputs with one cycle of latency.
module note_stack #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       remove,
    input  logic [3:0] key,
    output logic [3:0] top_next,
    output logic       empty_next
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [3:0]    entry_q [DEPTH];
    logic [3:0]    entry_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          found;
    logic [CW-1:0] found_idx;

    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && (CW'(i) < count_q) && (entry_q[i] == key)) begin
                found     = 1'b1;
                found_idx = CW'(i);
            end
        end
    end

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (push && !found) begin
            if (count_q == CW'(DEPTH)) begin
                // Full: slide everything down, discarding the oldest key.
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entry_d[i] = entry_q[i+1];
                end
                entry_d[DEPTH-1] = key;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == count_q) begin
                        entry_d[i] = key;
                    end
                end
                count_d = count_q + 1'b1;
            end
        end else if (remove && found) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (CW'(i) >= found_idx) begin
                    entry_d[i] = entry_q[i+1];
                end
            end
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        top_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count_d) begin
                top_next = entry_d[i];
            end
        end
    end

    assign empty_next = (count_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-code parser driving note/octave/gate to the tone generator.
// Define SUSTAIN_EN to add the space-bar sustain latch.
module ps2_note_decoder
    import ps2_note_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned OCT_INIT       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    output logic [3:0] note,
    output logic [2:0] octave,
    output logic       gate,
    output logic       note_event
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    octave_q, octave_d;
    logic [3:0]    note_q, note_d;
    logic          gate_q, gate_d;
    logic          event_q, event_d;
    logic          push, remove;
    logic [3:0]    top_next;
    logic          empty_next;
    key_t          code_key;

`ifdef SUSTAIN_EN
    logic sustain_q, sustain_d;
    logic latched_q, latched_d;
`endif

    assign code_key = key_lookup(ps2_data);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        octave_d = octave_q;
        push     = 1'b0;
        remove   = 1'b0;
`ifdef SUSTAIN_EN
        sustain_d = sustain_q;
`endif
        if (ps2_valid) begin
            timer_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (ps2_data == ScBreak) begin
                        state_d = StBreak;
                    end else if (ps2_data == ScExt) begin
                        state_d = StExt;
                    end else if (code_key.hit) begin
                        push = 1'b1;
                    end else if (ps2_data == ScOctDown) begin
                        if (octave_q != 3'd0) octave_d = octave_q - 3'd1;
                    end else if (ps2_data == ScOctUp) begin
                        if (octave_q != 3'd7) octave_d = octave_q + 3'd1;
                    end
`ifdef SUSTAIN_EN
                    else if (ps2_data == ScSpace) begin
                        sustain_d = 1'b1;
                    end
`endif
                end
                StBreak: begin
                    state_d = StIdle;
                    remove  = code_key.hit;
`ifdef SUSTAIN_EN
                    if (ps2_data == ScSpace) sustain_d = 1'b0;
`endif
                end
                StExt: begin
                    state_d = (ps2_data == ScBreak) ? StExtBreak : StIdle;
                end
                StExtBreak: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end else if (state_q != StIdle) begin
            // A byte on the expiry cycle takes the branch above, so it is never lost.
            if (timer_q == TimerLast) begin
                state_d = StIdle;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    note_stack #(
        .DEPTH(DEPTH)
    ) u_note_stack (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .push      (push),
        .remove    (remove),
        .key       (code_key.note),
        .top_next  (top_next),
        .empty_next(empty_next)
    );

`ifdef SUSTAIN_EN
    // latched remembers that a note sounded since sustain went down.
    assign latched_d = !empty_next || (latched_q && sustain_d);
    assign gate_d    = !empty_next || (sustain_d && latched_q);
`else
    assign gate_d = !empty_next;
`endif

    assign note_d  = empty_next ? note_q : top_next;
    assign event_d = (gate_d != gate_q) ||
                     (gate_d && ((note_d != note_q) || (octave_d != octave_q)));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            octave_q <= 3'(OCT_INIT);
            note_q   <= '0;
            gate_q   <= 1'b0;
            event_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            octave_q <= octave_d;
            note_q   <= note_d;
            gate_q   <= gate_d;
            event_q  <= event_d;
        end
    end

`ifdef SUSTAIN_EN
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sustain_q <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            sustain_q <= sustain_d;
            latched_q <= latched_d;
        end
    end
`endif

    assign note       = note_q;
    assign octave     = octave_q;
    assign gate       = gate_q;
    assign note_event = event_q;

endmodule
